// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: blocking read controller for a direct-mapped cache with
// critical-word capture during line refill and hit/miss performance counters.
module cache_refill_ctrl #(
  parameter int INDEX_LENGTH = 4,
  parameter int TAG_LENGTH = 22,
  parameter int OFFSET_LENGTH = 2,
  parameter int DATA_WIDTH = 32,
  localparam int ADDR_W = TAG_LENGTH + INDEX_LENGTH + OFFSET_LENGTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cpu_req_i,
  input  logic [ADDR_W-1:0]                     cpu_addr_i,
  output logic                                  cpu_ready_o,
  output logic                                  cpu_valid_o,
  output logic [DATA_WIDTH-1:0]                 cpu_data_o,
  output logic [INDEX_LENGTH-1:0]               tag_index_o,
  input  logic [TAG_LENGTH-1:0]                 tag_rdata_i,
  input  logic                                  tag_free_i,
  output logic                                  tag_we_o,
  output logic                                  tag_deload_o,
  output logic [TAG_LENGTH-1:0]                 tag_wdata_o,
  output logic [INDEX_LENGTH+OFFSET_LENGTH-1:0] data_addr_o,
  output logic                                  data_we_o,
  output logic [DATA_WIDTH-1:0]                 data_wdata_o,
  input  logic [DATA_WIDTH-1:0]                 data_rdata_i,
  output logic                                  mem_req_o,
  output logic [ADDR_W-1:0]                     mem_addr_o,
  input  logic                                  mem_ack_i,
  input  logic                                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
  output logic [15:0]                           hit_cnt_o,
  output logic [15:0]                           miss_cnt_o
);
  typedef enum logic [2:0] {IDLE, LOOKUP, HIT_RD, EVICT, FETCH_REQ, REFILL, UPDATE, RESPOND} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [OFFSET_LENGTH-1:0] r_beat;
  logic [DATA_WIDTH-1:0] r_crit;
  logic [15:0] r_hit_cnt, r_miss_cnt;
  logic [TAG_LENGTH-1:0] w_tag;
  logic [INDEX_LENGTH-1:0] w_index;
  logic [OFFSET_LENGTH-1:0] w_offset;
  logic w_hit, w_beat_in, w_last;
  assign {w_tag, w_index, w_offset} = r_addr;
  assign w_hit = !tag_free_i && tag_rdata_i == w_tag;
  assign w_beat_in = r_state == REFILL && mem_rvalid_i;
  assign w_last = r_beat == {OFFSET_LENGTH{1'b1}};
  assign hit_cnt_o = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_beat <= '0;
      r_crit <= '0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && cpu_req_i) r_addr <= cpu_addr_i;
      if (r_state == FETCH_REQ) r_beat <= '0;
      else if (w_beat_in) r_beat <= r_beat + 1'b1;
      if (w_beat_in && r_beat == w_offset) r_crit <= mem_rdata_i;
      if (r_state == LOOKUP && w_hit) r_hit_cnt <= r_hit_cnt + 16'd1;
      if (r_state == LOOKUP && !w_hit) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end
  // Strobes are gated by rst so nothing is written during the reset cycle itself.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = cpu_req_i ? LOOKUP : IDLE;
      LOOKUP:    w_next = w_hit ? HIT_RD : tag_free_i ? FETCH_REQ : EVICT;
      HIT_RD:    w_next = IDLE;
      EVICT:     w_next = FETCH_REQ;
      FETCH_REQ: w_next = mem_ack_i ? REFILL : FETCH_REQ;
      REFILL:    w_next = w_beat_in && w_last ? UPDATE : REFILL;
      UPDATE:    w_next = RESPOND;
      RESPOND:   w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    cpu_ready_o = r_state == IDLE;
    cpu_valid_o = !rst && (r_state == HIT_RD || r_state == RESPOND);
    cpu_data_o = r_state == HIT_RD ? data_rdata_i : r_state == RESPOND ? r_crit : '0;
    tag_index_o = w_index;
    tag_wdata_o = w_tag;
    tag_we_o = !rst && r_state == UPDATE;
    tag_deload_o = !rst && r_state == EVICT;
    mem_req_o = !rst && r_state == FETCH_REQ;
    mem_addr_o = {w_tag, w_index, {OFFSET_LENGTH{1'b0}}};
    data_we_o = !rst && w_beat_in;
    data_addr_o = {w_index, r_state == REFILL ? r_beat : w_offset};
    data_wdata_o = mem_rdata_i;
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed and randomized reads checked against a
// line-level cache/memory model, with tb-owned tag/data stores and memory.
module tb_cache_refill_ctrl;
  localparam int IL = 4, TL = 22, OL = 2, DW = 32, AW = TL + IL + OL;
  logic clk = 0, rst = 1;
  logic cpu_req_i = 0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic cpu_ready_o, cpu_valid_o, tag_free_i, tag_we_o, tag_deload_o, data_we_o, mem_req_o;
  logic [DW-1:0] cpu_data_o, data_wdata_o, data_rdata_i, mem_rdata_i;
  logic [IL-1:0] tag_index_o;
  logic [TL-1:0] tag_rdata_i, tag_wdata_o;
  logic [IL+OL-1:0] data_addr_o;
  logic [AW-1:0] mem_addr_o;
  logic mem_ack_i, mem_rvalid_i;
  logic [15:0] hit_cnt_o, miss_cnt_o;
  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i),
    .cpu_ready_o(cpu_ready_o), .cpu_valid_o(cpu_valid_o), .cpu_data_o(cpu_data_o),
    .tag_index_o(tag_index_o), .tag_rdata_i(tag_rdata_i), .tag_free_i(tag_free_i),
    .tag_we_o(tag_we_o), .tag_deload_o(tag_deload_o), .tag_wdata_o(tag_wdata_o),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  function automatic logic [DW-1:0] mw(input logic [AW-1:0] a);
    return {4'hA, a};
  endfunction

  // tag/data stores plus event monitor
  logic [TL-1:0] ts_tag [16];
  logic ts_val [16];
  logic [DW-1:0] ds [64];
  logic pl_en = 0, pl_clr = 0;
  logic [IL-1:0] pl_idx = '0;
  logic [OL-1:0] pl_off = '0;
  logic [TL-1:0] pl_tag = '0;
  logic [DW-1:0] pl_data = '0;
  int n_dwe = 0, n_twe = 0, n_del = 0, n_val = 0, n_reqcyc = 0, del_at_req = 0;
  logic [TL-1:0] last_twd = '0;
  assign tag_rdata_i = ts_tag[tag_index_o];
  assign tag_free_i = !ts_val[tag_index_o];
  always @(posedge clk) begin
    data_rdata_i <= ds[data_addr_o];
    if (data_we_o) begin ds[data_addr_o] <= data_wdata_o; n_dwe <= n_dwe + 1; end
    if (tag_we_o) begin ts_tag[tag_index_o] <= tag_wdata_o; ts_val[tag_index_o] <= 1'b1; n_twe <= n_twe + 1; last_twd <= tag_wdata_o; end
    if (tag_deload_o) begin ts_val[tag_index_o] <= 1'b0; n_del <= n_del + 1; end
    if (cpu_valid_o) n_val <= n_val + 1;
    if (mem_req_o) begin n_reqcyc <= n_reqcyc + 1; del_at_req <= n_del; end
    if (pl_clr) for (int i = 0; i < 16; i++) ts_val[i] <= 1'b0;
    if (pl_en) begin ts_tag[pl_idx] <= pl_tag; ts_val[pl_idx] <= 1'b1; ds[{pl_idx, pl_off}] <= pl_data; end
  end

  // memory responder
  int ack_dly = 0, max_gap = 0;
  bit rbusy = 0;
  logic [AW-1:0] rbase;
  initial begin
    mem_ack_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o) begin
        rbusy = 1;
        rbase = mem_addr_o;
        repeat (ack_dly) @(negedge clk);
        mem_ack_i = 1;
        @(negedge clk);
        mem_ack_i = 0;
        for (int b = 0; b < 4; b++) begin
          repeat ($urandom_range(max_gap, 0)) @(negedge clk);
          mem_rvalid_i = 1; mem_rdata_i = mw(rbase + AW'(b));
          @(negedge clk);
          mem_rvalid_i = 0; mem_rdata_i = $urandom;
        end
        rbusy = 0;
      end
    end
  end

  // reference model: line-level cache contents and counters
  logic [TL-1:0] m_tag [16];
  bit m_val [16];
  logic [DW-1:0] m_data [64];
  logic [15:0] m_hits = '0, m_miss = '0;
  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_free();
    int k = 0;
    while ((!cpu_ready_o || rbusy) && k < 200) begin @(negedge clk); k++; end
    chk("idle_wait", {31'd0, cpu_ready_o && !rbusy}, 32'd1);
  endtask

  task automatic do_req(input logic [TL-1:0] t, input logic [IL-1:0] i, input logic [OL-1:0] o);
    logic [AW-1:0] a;
    logic hit, ev;
    logic [DW-1:0] exp_d;
    int k, d0, w0, e0, v0, r0;
    a = {t, i, o};
    hit = m_val[i] && m_tag[i] == t;
    ev = !hit && m_val[i];
    exp_d = hit ? m_data[{i, o}] : mw(a);
    wait_free();
    d0 = n_dwe; w0 = n_twe; e0 = n_del; v0 = n_val; r0 = n_reqcyc;
    cpu_req_i = 1; cpu_addr_i = a;
    @(negedge clk);
    cpu_req_i = 0; cpu_addr_i = AW'($urandom);
    k = 1;
    while (!cpu_valid_o && k < 300) begin @(negedge clk); k++; end
    chk("valid_seen", {31'd0, cpu_valid_o}, 32'd1);
    chk("rd_data", cpu_data_o, exp_d);
    if (hit) chk("hit_latency", k, 2);
    if (hit) m_hits = m_hits + 16'd1;
    else begin
      m_miss = m_miss + 16'd1;
      m_val[i] = 1; m_tag[i] = t;
      for (int w = 0; w < 4; w++) m_data[{i, OL'(w)}] = mw({t, i, OL'(w)});
    end
    @(negedge clk);
    chk("hit_cnt", {16'd0, hit_cnt_o}, {16'd0, m_hits});
    chk("miss_cnt", {16'd0, miss_cnt_o}, {16'd0, m_miss});
    chk("deload_n", n_del - e0, {31'd0, ev});
    chk("tag_we_n", n_twe - w0, hit ? 0 : 1);
    chk("data_we_n", n_dwe - d0, hit ? 0 : 4);
    chk("valid_n", n_val - v0, 1);
    chk("req_cycles", n_reqcyc - r0, hit ? 0 : ack_dly + 1);
    if (!hit) chk("tag_wdata", {10'd0, last_twd}, {10'd0, t});
    if (ev) chk("deload_before_req", del_at_req - e0, 1);
  endtask

  initial begin
    int k, d0, w0;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    pl_clr = 1;
    repeat (3) @(negedge clk);
    pl_clr = 0;
    chk("rst_ready", {31'd0, cpu_ready_o}, 32'd1);
    chk("rst_strobes", {27'd0, cpu_valid_o, tag_we_o, tag_deload_o, data_we_o, mem_req_o}, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("rst_ready_after", {31'd0, cpu_ready_o}, 32'd1);
    chk("rst_cnt", {hit_cnt_o, miss_cnt_o}, 32'd0);
    chk("rst_data", cpu_data_o, 32'd0);
    // preloaded hit
    pl_en = 1; pl_idx = 3; pl_off = 1; pl_tag = 22'h12; pl_data = 32'hCAFEF00D;
    @(negedge clk);
    pl_en = 0;
    m_val[3] = 1; m_tag[3] = 22'h12; m_data[{4'd3, 2'd1}] = 32'hCAFEF00D;
    do_req(22'h12, 3, 1);
    // cold miss, conflict miss, stalled memory
    do_req(22'h7, 5, 2);
    do_req(22'h9, 5, 0);
    ack_dly = 3; max_gap = 2;
    do_req(22'h4, 6, 3);
    // reset in the middle of a refill
    ack_dly = 0; max_gap = 0;
    wait_free();
    d0 = n_dwe; w0 = n_twe;
    cpu_req_i = 1; cpu_addr_i = {22'h5, 4'd7, 2'd1};
    @(negedge clk);
    cpu_req_i = 0;
    k = 0;
    while (n_dwe - d0 < 2 && k < 200) begin @(negedge clk); k++; end
    chk("mid_refill_beats", n_dwe - d0, 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_hits = '0; m_miss = '0;
    chk("mid_rst_ready", {31'd0, cpu_ready_o}, 32'd1);
    chk("mid_rst_cnt", {hit_cnt_o, miss_cnt_o}, 32'd0);
    k = 0;
    while (rbusy && k < 200) begin @(negedge clk); k++; end
    @(negedge clk);
    chk("mid_rst_tag_we", n_twe - w0, 0);
    chk("mid_rst_trailing", n_dwe - d0, 2);
    do_req(22'h5, 7, 1);
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ack_dly = $urandom_range(3, 0);
      max_gap = $urandom_range(2, 0);
      do_req(TL'($urandom_range(3, 1)), IL'($urandom_range(3, 0)), OL'($urandom_range(3, 0)));
    end
    // hit counter wrap
    ack_dly = 0; max_gap = 0;
    wait_free();
    force dut.r_hit_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_hit_cnt;
    m_hits = 16'hFFFF;
    do_req(22'h9, 5, 3);
    chk("hit_wrap", {16'd0, hit_cnt_o}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameters: INDEX_LENGTH, default 4, cache index bits; TAG_LENGTH, default 22, tag bits; OFFSET_LENGTH, default 2, word-in-line bits (4 words/line); DATA_WIDTH, default 32, word width.
REQ-002 Derived: ADDR_W = TAG_LENGTH+INDEX_LENGTH+OFFSET_LENGTH (word address); address fields = {tag, index, offset}, MSB to LSB.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req_i  in  1  read request, sampled only while cpu_ready_o=1.
REQ-006 cpu_addr_i  in  ADDR_W  word address of the request.
REQ-007 cpu_ready_o  out  1  controller idle and accepting a request.
REQ-008 cpu_valid_o  out  1  one-cycle pulse: cpu_data_o valid.
REQ-009 cpu_data_o  out  DATA_WIDTH  read data.
REQ-010 tag_index_o  out  INDEX_LENGTH  index to tag store.
REQ-011 tag_rdata_i  in  TAG_LENGTH  stored tag, combinational from tag_index_o.
REQ-012 tag_free_i  in  1  addressed line empty, combinational.
REQ-013 tag_we_o / tag_deload_o  out  1 each  tag write / line invalidate strobes.
REQ-014 tag_wdata_o  out  TAG_LENGTH  tag to write.
REQ-015 data_addr_o  out  INDEX_LENGTH+OFFSET_LENGTH  data store address; data_we_o  out  1; data_wdata_o  out  DATA_WIDTH.
REQ-016 data_rdata_i  in  DATA_WIDTH  data store read, valid one cycle after data_addr_o.
REQ-017 mem_req_o  out  1  line fetch request; mem_addr_o  out  ADDR_W  line base (offset=0).
REQ-018 mem_ack_i  in  1  request accepted; mem_rvalid_i  in  1  beat valid; mem_rdata_i  in  DATA_WIDTH  beat data, beats in ascending offset order.
REQ-019 hit_cnt_o, miss_cnt_o  out  16 each  performance counters.

Function
REQ-020 States: IDLE, LOOKUP, HIT_RD, EVICT, FETCH_REQ, REFILL, UPDATE, RESPOND; only IDLE asserts cpu_ready_o.
REQ-021 IDLE: cpu_req_i=1 -> latch cpu_addr_i into addr_q, go LOOKUP; else stay.
REQ-022 All tag/data/mem addresses derive from addr_q, never from live cpu_addr_i.
REQ-023 LOOKUP: hit = !tag_free_i && tag_rdata_i==addr_q.tag; drive data_addr_o={index,offset}; hit -> HIT_RD, hit_cnt_o+1; miss with tag_free_i=1 -> FETCH_REQ; miss with tag_free_i=0 -> EVICT; either miss increments miss_cnt_o.
REQ-024 HIT_RD: cpu_valid_o=1, cpu_data_o=data_rdata_i, go IDLE; hit latency = request accepted cycle N, valid cycle N+2.
REQ-025 EVICT: tag_deload_o=1 for exactly one cycle, go FETCH_REQ.
REQ-026 FETCH_REQ: mem_req_o=1, mem_addr_o={tag,index,0}; held until mem_ack_i=1 sampled, then REFILL with beat counter=0.
REQ-027 REFILL: per mem_rvalid_i=1: data_we_o=1, data_addr_o={index,beat}, data_wdata_o=mem_rdata_i, beat+1; beat==addr_q.offset also captures mem_rdata_i into crit_q; last beat (2^OFFSET_LENGTH-1) -> UPDATE; mem_rvalid_i=0 cycles stall with no writes.
REQ-028 UPDATE: tag_we_o=1, tag_wdata_o=addr_q.tag for one cycle, go RESPOND.
REQ-029 RESPOND: cpu_valid_o=1, cpu_data_o=crit_q, go IDLE.
REQ-030 mem_rvalid_i/mem_ack_i outside FETCH_REQ/REFILL ignored; cpu_req_i while not IDLE ignored.
REQ-031 Beat counter OFFSET_LENGTH bits; counters wrap 0xFFFF->0x0000.
REQ-032 Strobes (tag_we_o, tag_deload_o, data_we_o, mem_req_o, cpu_valid_o) never asserted outside their stated states.

Reset
REQ-033 rst=1 at any edge, in any state: next state IDLE, addr_q/beat/crit_q/counters=0, all strobes 0, cpu_data_o=0, cpu_ready_o=1 in the following cycle.
REQ-034 rst mid-REFILL: pending beats dropped, no tag_we_o issued, partial line left untagged.

Verification
REQ-035 Hit: tag store holds tag 0x12 at index 3, data[3,1]=0xCAFEF00D; request addr {0x12,3,1} -> cpu_valid_o two cycles after acceptance, data 0xCAFEF00D, hit_cnt_o=1.
REQ-036 Cold miss: index 5 free, request {0x7,5,2}, memory returns 0xA0..0xA3 -> four data writes at {5,0..3}, tag_we_o with 0x7, no tag_deload_o, cpu_data_o=0xA2, miss_cnt_o=1.
REQ-037 Conflict miss: index 5 holds 0x7, request {0x9,5,0} -> one tag_deload_o pulse before mem_req_o, tag_we_o 0x9, cpu_data_o = beat 0.
REQ-038 Stalled memory: mem_ack_i delayed 3 cycles, idle cycles between beats -> mem_req_o held, data writes only on mem_rvalid_i, correct critical word.
REQ-039 Reset mid-REFILL after 2 beats -> IDLE next cycle, cpu_ready_o=1, counters 0, no tag_we_o, trailing mem_rvalid_i ignored.
REQ-040 Counter wrap: preload 0xFFFF hits then one hit -> hit_cnt_o=0x0000.
